// File: rtl/fifo_bit_packer_if.sv
// Read-side FIFO bit interface plus packed-word valid/ready output.
// The packer uses the slave view; whoever feeds it uses the master view.
interface fifo_bit_packer_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LEN_W = $clog2(WIDTH) + 1;

    logic             empty;
    logic             data_1b_in;
    logic             rd_en;
    logic             flush;
    logic [WIDTH-1:0] word_out;
    logic [LEN_W-1:0] word_len;
    logic             word_valid;
    logic             word_ready;

    modport slave (
        input  empty, data_1b_in, flush, word_ready,
        output rd_en, word_out, word_len, word_valid
    );

    modport master (
        output empty, data_1b_in, flush, word_ready,
        input  rd_en, word_out, word_len, word_valid
    );
endinterface

// File: rtl/fifo_bit_packer.sv
// Drains a 1-bit FIFO one bit per cycle and packs the bits into WIDTH-bit words
// presented on a valid/ready port; a flush publishes a partially filled word.
module fifo_bit_packer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst,
    fifo_bit_packer_if.slave bus
);
    localparam int unsigned      LEN_W    = $clog2(WIDTH) + 1;
    localparam int unsigned      IDX_W    = $clog2(WIDTH);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             cap_q, cap_d;
    logic             flush_pend_q, flush_pend_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             valid_q, valid_d;
    logic             rd_en_c;
    logic [LEN_W-1:0] fill_c;

    // Bits already captured plus the one in flight from the FIFO.
    assign fill_c = cnt_q + LEN_W'(cap_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_COLLECT;
            cnt_q        <= '0;
            cap_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            word_q       <= '0;
            len_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            flush_pend_q <= flush_pend_d;
            word_q       <= word_d;
            len_q        <= len_d;
            valid_q      <= valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_pend_d = flush_pend_q | bus.flush;
        word_d       = word_q;
        len_d        = len_q;
        valid_d      = valid_q;
        rd_en_c      = 1'b0;

        case (state_q)
            ST_COLLECT: begin
                // rst gating keeps the pop request low while held in reset.
                rd_en_c = rst && !bus.empty && !flush_pend_q && (fill_c < FULL_LEN);
                if (cap_q) begin
                    if (LSB_FIRST) begin
                        word_d[cnt_q[IDX_W-1:0]] = bus.data_1b_in;
                    end else begin
                        word_d = {word_q[WIDTH-2:0], bus.data_1b_in};
                    end
                    cnt_d = cnt_q + LEN_W'(1);
                    if (cnt_q == LAST_IDX) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        len_d   = FULL_LEN;
                        cnt_d   = '0;
                    end
                end else if (flush_pend_q) begin
                    // Serviced only once no popped bit is still in flight.
                    flush_pend_d = bus.flush;
                    if (cnt_q != '0) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        len_d   = cnt_q;
                        cnt_d   = '0;
                        if (!LSB_FIRST) begin
                            word_d = word_q << (FULL_LEN - cnt_q);
                        end
                    end
                end
            end

            ST_HOLD: begin
                if (bus.word_ready) begin
                    state_d = ST_COLLECT;
                    valid_d = 1'b0;
                    word_d  = '0;
                end
            end

            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    assign cap_d          = rd_en_c;
    assign bus.rd_en      = rd_en_c;
    assign bus.word_out   = word_q;
    assign bus.word_len   = len_q;
    assign bus.word_valid = valid_q;
endmodule

// File: doc/fifo_bit_packer.md
# fifo_bit_packer

Read-side companion to the 1-bit board FIFO: drains single bits through the FIFO's `rd_en`/`empty`/data-out interface and packs them into `WIDTH`-bit words. Each word is presented on a valid/ready output for LED display or a downstream consumer. The block runs on the FIFO's clock, so one bit can be popped per cycle. A flush request publishes a partially filled word.

## Interface

- `WIDTH`, 8: bits per packed word (≥2).
- `LSB_FIRST`, 1: 1 = first popped bit lands in `word_out[0]`; 0 = first bit lands in `word_out[WIDTH-1]`.
- `clk`  in  1  single clock, shared with the FIFO.
- `rst`  in  1  asynchronous, active-low reset.
- `empty`  in  1  FIFO empty flag.
- `data_1b_in`  in  1  FIFO registered read data; valid the cycle after a pop.
- `rd_en`  out  1  pop request to the FIFO (combinational).
- `flush`  in  1  single-cycle pulse: publish the partial word.
- `word_out`  out  WIDTH  packed word (registered).
- `word_len`  out  $clog2(WIDTH)+1  number of valid bits in `word_out`.
- `word_valid`  out  1  word available.
- `word_ready`  in  1  consumer accepts word.

## Operation

- **Reset values** (`rst`=0, asynchronous):
  - State COLLECT.
  - `cnt`=0, `cap`=0, `flush_pend`=0.
  - Outputs `word_out`=0, `word_len`=0, `word_valid`=0, `rd_en`=0.
- **Internal state:**
  - `cnt`: bits captured into the current word.
  - `cap`: registered copy of `rd_en`; marks that `data_1b_in` holds a freshly popped bit.
  - `flush_pend`: flush requested, not yet serviced.
- **COLLECT state:**
  - `rd_en` = `!empty && !flush_pend && (cnt + cap) < WIDTH`.
  - Each cycle with `cap`=1, `data_1b_in` is shifted into the word and `cnt` increments.
  - With `LSB_FIRST`=1, bit i of the stream goes to `word_out[i]`.
  - With `LSB_FIRST`=0, bits shift in from the LSB end and the result is MSB-aligned.
- **Full word:** the capture that makes `cnt`=WIDTH moves to HOLD.
  - `word_valid`=1 and `word_len`=WIDTH.
  - `cnt` clears.
- **Flush:**
  - `flush` sets `flush_pend`, which blocks new pops.
  - Once `cap`=0: if `cnt`>0, go to HOLD with `word_len`=`cnt`. Unused bits are 0 (high bits for LSB_FIRST, low bits for MSB_FIRST).
  - If `cnt`=0, `flush_pend` clears and nothing is emitted.
  - A flush arriving during HOLD is held pending and serviced after acceptance.
- **HOLD state:**
  - `rd_en`=0.
  - `word_out`/`word_len` stay stable while `word_valid`=1.
  - On a clock edge with `word_ready`=1: `word_valid`→0 and return to COLLECT. `word_len` is held; `word_out` clears before the next capture.
- **Empty:** `rd_en` is never asserted while `empty`=1. Bits accumulate across empty gaps with no timeout.
- **Reset mid-word or mid-HOLD:** discards the partial word and the presented word, with no further outputs.

## Timing

- A pop occurs at the edge ending cycle k (`rd_en`=1, `empty`=0). `cap`=1 in cycle k+1, and the bit is captured at the edge ending cycle k+1.
- Steady state (FIFO never empty, `word_ready` held 1):
  - `rd_en` high for cycles 0..WIDTH-1.
  - `word_valid` high in cycle WIDTH+1 for one cycle.
  - Next `rd_en` in cycle WIDTH+2.
  - Throughput: one word per WIDTH+2 cycles.
- `rd_en` may be high in the same cycle a previous bit is captured (pipelined). `data_1b_in` is sampled at the edge, before the FIFO updates it.
- `word_valid` rises exactly one cycle after the final capture or after the flush condition is met.
- Acceptance takes one edge. A word is never dropped or duplicated.

## Test plan

- **Basic pack:** WIDTH=8, LSB_FIRST=1, FIFO preloaded with bits 1,0,1,1,0,0,1,0, `word_ready`=1 → `rd_en` high for 8 consecutive cycles, then `word_out`=0x4D, `word_len`=8, `word_valid` pulses 1 cycle at cycle 9. With LSB_FIRST=0 the same stream gives `word_out`=0xB2.
- **Backpressure:** 16 bits preloaded (0x4D stream twice), `word_ready`=0 for 20 cycles after the first valid → exactly 8 pops, then `rd_en`=0 and `word_out` stable at 0x4D. After ready, the second 0x4D follows; 16 pops in total.
- **Empty gaps:** bits fed one every 5 cycles with `empty`=1 between → `rd_en` never high while empty; the word is still 0x4D after 8 bits.
- **Flush partial:** push 1,1,0, then pulse `flush` while a pop is in flight → no new `rd_en` after the flush; `word_out`=0x03, `word_len`=3. Flush with `cnt`=0 → no `word_valid`.
- **Reset mid-word:** assert `rst`=0 after 5 captured bits → all outputs 0 immediately (asynchronous). After release, a fresh 8-bit stream yields the correct word with no stale bits.
- **Random soak:** random `empty`/`word_ready`/`flush` → the scoreboard bit stream matches concatenated words, with no pops while `empty`=1 and no pops during HOLD.
